servo_pwm_multi: RTL
====================

Name: servo_pwm_multi

Overview:
Multi-channel RC/continuous-servo PWM generator for the Segway fabric. It replaces the single fixed servo output driven from MSS GPIO. Firmware writes per-channel pulse-width targets over a simple write strobe. The block emits glitch-free, frame-synchronous pulses with optional per-frame slew limiting so the drive servos never see step commands.

Parameters:
NUM_CH, 4, number of servo channels (1..16)
PRESCALE, 10, SYSCLK cycles per 1 us tick (10 MHz SYSCLK)
FRAME_US, 20000, frame period in ticks
MIN_US, 1000, minimum legal pulse width in ticks
MAX_US, 2000, maximum legal pulse width in ticks
NEUTRAL_US, 1500, reset and stop pulse width
SLEW_US, 10, maximum change of active width per frame when ramping
W, 16, width of all tick counts; W must satisfy 2^W > FRAME_US

Ports:
SYSCLK  in  1  system clock
SYSRESET  in  1  asynchronous, active-high reset
WR_EN  in  1  one-cycle write strobe
WR_CH  in  4  target channel index for the write
WR_DATA  in  W  requested pulse width in ticks
EN_MASK  in  NUM_CH  per-channel output enable
RAMP_EN  in  1  1 = slew-limited update, 0 = immediate update
RD_CH  in  4  channel selected for readback
RD_DATA  out  W  active width of RD_CH, registered
WR_ERR  out  1  one-cycle pulse on an out-of-range WR_CH
FRAME_STB  out  1  one-cycle pulse at each frame start
PWM  out  NUM_CH  servo pulse outputs

Behaviour:
- Reset (async assert, sync release):
  - prescaler=0, frame_cnt=0
  - target[i]=active[i]=NEUTRAL_US, en_q[i]=0
  - PWM=0, FRAME_STB=0, WR_ERR=0, RD_DATA=NEUTRAL_US
  - Reset mid-pulse drops PWM low immediately.
- Tick generation:
  - prescaler counts 0..PRESCALE-1.
  - tick=1 on the cycle it equals PRESCALE-1; it then wraps to 0.
- Frame counter:
  - On tick, frame_cnt increments.
  - At FRAME_US-1, the next tick wraps it to 0. That same cycle is the "boundary" and FRAME_STB=1 for exactly one cycle.
- Writes:
  - WR_EN with WR_CH<NUM_CH loads target[WR_CH]=clamp(WR_DATA, MIN_US, MAX_US) on the next edge.
  - WR_CH>=NUM_CH: no state change; WR_ERR=1 the next cycle.
  - Back-to-back writes are allowed every cycle; the last write wins.
- Boundary update, per channel, using register values before the edge:
  - en_q[i] <= EN_MASK[i].
  - RAMP_EN=0: active[i] <= target[i].
  - RAMP_EN=1: active[i] moves toward target[i] by min(SLEW_US, |target-active|). It never overshoots.
  - A write coinciding with the boundary edge is not seen by this update. It applies at the next boundary.
- Output:
  - PWM[i] <= en_q[i] & (frame_cnt < active[i]), registered.
  - Rising edge appears 1 SYSCLK after the boundary cycle.
  - Pulse high time is exactly active[i] ticks.
  - active, enable and mode never change mid-frame, so there are no runt or stretched pulses.
- RD_DATA <= active[RD_CH] each cycle (1-cycle latency). RD_CH>=NUM_CH returns 0.
- Arithmetic:
  - All counts are unsigned, W bits.
  - Clamp compares use W bits; WR_DATA values above MAX_US, including all-ones, clamp to MAX_US.
  - Slew difference uses W+1 bits to avoid wrap.

Decomposition:
- Shared package/include servo_pkg holds:
  - default constants: NEUTRAL_US, MIN_US, MAX_US, FRAME_US, SLEW_US
  - a clamp function
- Natural sub-module servo_pwm_channel, generated NUM_CH times. It holds target, active, en_q, the slew logic and the compare/PWM register.
- Prescaler, frame counter, write decode and readback mux stay in servo_pwm_multi.

Test Plan:
Bench parameters: PRESCALE=10, FRAME_US=100, MIN_US=10, MAX_US=50, NEUTRAL_US=30, SLEW_US=4, NUM_CH=4.
1. Reset release, EN_MASK=4'hF:
   - FRAME_STB every 1000 SYSCLK.
   - Every PWM high for 30 ticks (300 cycles) starting 1 cycle after FRAME_STB.
   - RD_DATA=30.
2. RAMP_EN=0, write ch1=45 mid-frame:
   - Current frame ch1 stays 30 ticks; the next frame it is 45 ticks.
   - Other channels are unchanged.
3. Clamp and error:
   - Write ch2=5 -> 10 ticks; write ch2=16'hFFFF -> 50 ticks.
   - WR_CH=7 -> WR_ERR one-cycle pulse, no channel changes.
4. RAMP_EN=1, ch0 target 30 -> 41: successive frames are 34, 38, 41, 41 ticks. RD_DATA tracks each step.
5. Write ch3=20 on the exact FRAME_STB cycle: next frame is still 30, the following frame is 20. EN_MASK[3] cleared mid-pulse: the current pulse completes, and PWM[3] is low from the next frame on.
6. Assert SYSRESET mid-pulse after writing ch0=50: PWM goes to 0 immediately. After release, all targets are 30 and the first frame shows 30-tick pulses.

Source files
------------

// File: rtl/servo_pkg.sv
// servo_pkg: shared servo PWM defaults (widths in 1 us ticks) and the pulse-width clamp helper
package servo_pkg;
  localparam int NEUTRAL_US = 1500;
  localparam int MIN_US = 1000;
  localparam int MAX_US = 2000;
  localparam int FRAME_US = 20000;
  localparam int SLEW_US = 10;
  function automatic logic [31:0] clamp(input logic [31:0] v, input logic [31:0] lo, input logic [31:0] hi);
    return v < lo ? lo : (v > hi ? hi : v);
  endfunction
endpackage

// File: rtl/servo_pwm_channel.sv
// servo_pwm_channel: one servo channel; holds target/active/enable, applies slew at frame boundary, drives registered pwm from frame_cnt < active
module servo_pwm_channel #(
  parameter int W = 16,
  parameter int NEUTRAL_US = 1500,
  parameter int SLEW_US = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         boundary,
  input  logic         wr,
  input  logic         ramp,
  input  logic         en,
  input  logic [W-1:0] wr_data,
  input  logic [W-1:0] frame_cnt,
  output logic [W-1:0] active,
  output logic         pwm
);
  logic [W-1:0] target, step, nxt;
  logic [W:0] diff, mag;
  logic en_q;
  always_comb begin
    diff = {1'b0, target} - {1'b0, active};
    mag = diff[W] ? -diff : diff;
    step = mag > (W+1)'(SLEW_US) ? W'(SLEW_US) : mag[W-1:0];
    nxt = ramp ? (diff[W] ? active - step : active + step) : target;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      target <= W'(NEUTRAL_US);
      active <= W'(NEUTRAL_US);
      en_q <= 1'b0;
      pwm <= 1'b0;
    end else begin
      if (wr) target <= wr_data;
      if (boundary) begin
        active <= nxt;
        en_q <= en;
      end
      pwm <= en_q && frame_cnt < active;
    end
endmodule

// File: rtl/servo_pwm_multi.sv
// servo_pwm_multi: multi-channel servo PWM; us-tick prescaler, frame counter/FRAME_STB, write decode with clamp and WR_ERR, RD_DATA readback, PWM[NUM_CH]
module servo_pwm_multi import servo_pkg::*; #(
  parameter int NUM_CH = 4,
  parameter int PRESCALE = 10,
  parameter int FRAME_US = servo_pkg::FRAME_US,
  parameter int MIN_US = servo_pkg::MIN_US,
  parameter int MAX_US = servo_pkg::MAX_US,
  parameter int NEUTRAL_US = servo_pkg::NEUTRAL_US,
  parameter int SLEW_US = servo_pkg::SLEW_US,
  parameter int W = 16
) (
  input  logic              SYSCLK,
  input  logic              SYSRESET,
  input  logic              WR_EN,
  input  logic [3:0]        WR_CH,
  input  logic [W-1:0]      WR_DATA,
  input  logic [NUM_CH-1:0] EN_MASK,
  input  logic              RAMP_EN,
  input  logic [3:0]        RD_CH,
  output logic [W-1:0]      RD_DATA,
  output logic              WR_ERR,
  output logic              FRAME_STB,
  output logic [NUM_CH-1:0] PWM
);
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  logic [PW-1:0] prescaler;
  logic [W-1:0] frame_cnt, wr_val, rd_nxt;
  logic [W-1:0] active [NUM_CH];
  logic tick;
  always_comb begin
    tick = prescaler == PW'(PRESCALE - 1);
    FRAME_STB = tick && frame_cnt == W'(FRAME_US - 1);
    wr_val = W'(clamp(32'(WR_DATA), 32'(MIN_US), 32'(MAX_US)));
    rd_nxt = '0;
    for (int i = 0; i < NUM_CH; i++) rd_nxt = RD_CH == 4'(i) ? active[i] : rd_nxt;
  end
  always_ff @(posedge SYSCLK or posedge SYSRESET)
    if (SYSRESET) begin
      prescaler <= '0;
      frame_cnt <= '0;
      WR_ERR <= 1'b0;
      RD_DATA <= W'(NEUTRAL_US);
    end else begin
      prescaler <= tick ? '0 : prescaler + PW'(1);
      if (tick) frame_cnt <= FRAME_STB ? '0 : frame_cnt + W'(1);
      WR_ERR <= WR_EN && {1'b0, WR_CH} >= 5'(NUM_CH);
      RD_DATA <= rd_nxt;
    end
  for (genvar g = 0; g < NUM_CH; g++) begin : ch
    servo_pwm_channel #(.W(W), .NEUTRAL_US(NEUTRAL_US), .SLEW_US(SLEW_US)) u_ch (
      .clk(SYSCLK),
      .rst(SYSRESET),
      .boundary(FRAME_STB),
      .wr(WR_EN && WR_CH == 4'(g)),
      .ramp(RAMP_EN),
      .en(EN_MASK[g]),
      .wr_data(wr_val),
      .frame_cnt(frame_cnt),
      .active(active[g]),
      .pwm(PWM[g])
    );
  end
endmodule
